// File: rtl/data_memory.sv
// Byte-addressed data memory with a fixed, parameterised access latency.
// BUSYWAIT stalls the CPU from the moment a request appears until the
// latched access completes LATENCY edges after it was accepted.
module data_memory #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] READDATA,
    output logic                  BUSYWAIT
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {
        StIdle,
        StAccess
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_count;
    logic [3:0]            w_count_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_is_read;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_accept;
    logic w_done;

    assign w_accept = (r_state == StIdle) & (READ | WRITE);
    assign w_done   = (r_state == StAccess) & (r_count == 4'd0);
    assign READDATA = r_rdata;

    // State and latency counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= StIdle;
            r_count <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Next-state, countdown and the combinational stall output.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        BUSYWAIT     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (READ | WRITE) begin
                    w_state_next = StAccess;
                    w_count_next = CNT_LOAD;
                end
                BUSYWAIT = READ | WRITE;
            end
            StAccess: begin
                if (r_count == 4'd0) begin
                    w_state_next = StIdle;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
                BUSYWAIT = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        // Reset must release the stall immediately, even with a request pending.
        if (RESET) begin
            BUSYWAIT = 1'b0;
        end
    end

    // Operand latch: inputs are sampled only at acceptance; READ wins over WRITE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_is_read <= 1'b0;
        end else if (w_accept) begin
            r_addr    <= ADDRESS;
            r_wdata   <= WRITEDATA;
            r_is_read <= READ;
        end
    end

    // Array update and registered load data, both only on the completion edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rdata <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i[ADDR_WIDTH-1:0]] <= '0;
            end
        end else if (w_done) begin
            if (r_is_read) begin
                r_rdata <= r_mem[r_addr];
            end else begin
                r_mem[r_addr] <= r_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: the driver queues each accepted access
// with its completion edge; the monitor retires it on that edge against a
// simple array model and checks BUSYWAIT/READDATA on every cycle.
module tb_data_memory;

    localparam int unsigned LAT = 5;

    logic       CLK;
    logic       RESET;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    data_memory #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8),
        .LATENCY   (LAT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .READ     (READ),
        .WRITE    (WRITE),
        .ADDRESS  (ADDRESS),
        .WRITEDATA(WRITEDATA),
        .READDATA (READDATA),
        .BUSYWAIT (BUSYWAIT)
    );

    typedef struct {
        bit          rd;
        logic [7:0]  a;
        logic [7:0]  d;
        int unsigned done;
    } item_t;

    item_t       sb[$];
    logic [7:0]  mem_m [256];
    logic [7:0]  model_rd;
    int unsigned cyc;
    int          total;
    int          bad;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        foreach (mem_m[i]) mem_m[i] = 8'h00;
        model_rd = 8'h00;
        sb.delete();
    endtask

    // Issue one access; optionally scramble inputs while it is in flight and
    // optionally keep the request asserted for 'extra' back-to-back repeats.
    task automatic access(input bit rd, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input bit garble, input int extra);
        int unsigned done;
        @(negedge CLK);
        READ      = rd;
        WRITE     = wr;
        ADDRESS   = a;
        WRITEDATA = d;
        #1;
        chk("busy_rise", 32'(BUSYWAIT), 32'd1);
        for (int n = 0; n <= extra; n++) begin
            done = cyc + 1 + LAT;
            sb.push_back('{rd: rd, a: a, d: d, done: done});
            do begin
                @(negedge CLK);
                if (cyc == done - 1) begin
                    if (n == extra) begin
                        READ  = 1'b0;
                        WRITE = 1'b0;
                    end else begin
                        READ      = rd;
                        WRITE     = wr;
                        ADDRESS   = a;
                        WRITEDATA = d;
                    end
                end else if (garble && cyc < done) begin
                    READ      = 1'($urandom);
                    WRITE     = 1'($urandom);
                    ADDRESS   = 8'($urandom);
                    WRITEDATA = 8'($urandom);
                end
            end while (cyc < done);
        end
    endtask

    // Write 0x77 to 0xFF and kill it with an asynchronous reset after E0+2.
    task automatic reset_mid();
        @(negedge CLK);
        READ      = 1'b0;
        WRITE     = 1'b1;
        ADDRESS   = 8'hFF;
        WRITEDATA = 8'h77;
        sb.push_back('{rd: 1'b0, a: 8'hFF, d: 8'h77, done: cyc + 1 + LAT});
        repeat (3) @(posedge CLK);
        #3;
        RESET = 1'b1;
        clear_model();
        #1;
        chk("midrst_busy", 32'(BUSYWAIT), 32'd0);
        chk("midrst_rdata", 32'(READDATA), 32'd0);
        @(negedge CLK);
        WRITE = 1'b0;
        READ  = 1'b1;
        #1;
        chk("rst_busy_req", 32'(BUSYWAIT), 32'd0);
        @(negedge CLK);
        READ  = 1'b0;
        RESET = 1'b0;
    endtask

    // Monitor: retire the head access on its completion edge, check outputs.
    initial begin
        item_t it;
        logic  exp_busy;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET) begin
                chk("mon_rst_busy", 32'(BUSYWAIT), 32'd0);
                chk("mon_rst_rdata", 32'(READDATA), 32'd0);
            end else begin
                if (sb.size() != 0 && sb[0].done == cyc) begin
                    it = sb.pop_front();
                    if (it.rd) model_rd = mem_m[it.a];
                    else       mem_m[it.a] = it.d;
                end
                exp_busy = (sb.size() != 0) || READ || WRITE;
                chk("mon_busy", 32'(BUSYWAIT), 32'(exp_busy));
                chk("mon_rdata", 32'(READDATA), 32'(model_rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit         rd;
        bit         wr;
        logic [7:0] a;
        total     = 0;
        bad       = 0;
        RESET     = 1'b1;
        READ      = 1'b1;
        WRITE     = 1'b0;
        ADDRESS   = 8'h00;
        WRITEDATA = 8'h00;
        clear_model();
        #2;
        chk("init_busy", 32'(BUSYWAIT), 32'd0);
        chk("init_rdata", 32'(READDATA), 32'd0);
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;

        access(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 0);  // write A5 @10
        access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 0);  // read back
        access(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 0);  // operands latched
        access(1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 0);  // read has priority
        access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 0);
        reset_mid();
        access(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 0);  // aborted write left 00
        access(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, 0);
        access(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1);  // back-to-back reads

        for (int k = 0; k < 40; k++) begin
            a = 8'($urandom_range(0, 7));
            if (a > 8'd3) a = a + 8'hF8;
            rd = 1'($urandom);
            wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
            access(rd, wr, a, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        repeat (3) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
